// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port among up to four cores
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   noc           number of active cores (0 acts as 1, above 4 acts as 4)
//   req, we       per-core level request and access type (1 = write)
//   grant         one-hot owner of the memory port (GRANT cycle)
//   mem_sel       index of the granted core for the address/data-in mux
//   mem_we        memory write enable for the granted access
//   data_out_en   one-hot read-data capture strobe (RESP cycle, reads only)
//   done          one-hot completion pulse (RESP cycle)
//   busy          high in GRANT and RESP
module mem_port_arbiter #(
    parameter int NCORES = 4,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        noc,
    input  logic [NCORES-1:0] req,
    input  logic [NCORES-1:0] we,
    output logic [NCORES-1:0] grant,
    output logic [SEL_W-1:0]  mem_sel,
    output logic              mem_we,
    output logic [NCORES-1:0] data_out_en,
    output logic [NCORES-1:0] done,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [SEL_W-1:0]  w_q, w_nxt;
    logic              we_q, we_nxt;

    logic [NCORES-1:0] grant_nxt, data_out_en_nxt, done_nxt;
    logic [SEL_W-1:0]  mem_sel_nxt;
    logic              mem_we_nxt, busy_nxt;

    logic [2:0]        noc_eff;
    logic [NCORES-1:0] mask, block, eligible;
    logic [SEL_W-1:0]  start, win, ptr_win;
    logic [2:0]        idx, win_inc;
    logic              found;

    always_comb begin
        if (noc == 3'd0)      noc_eff = 3'd1;
        else if (noc > 3'd4)  noc_eff = 3'd4;
        else                  noc_eff = noc;
    end

    // Round-robin search over the eligible set. In RESP the core just served
    // still holds req, so it is blocked from winning the immediate rearbitration.
    always_comb begin
        case (noc_eff)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0011;
            3'd3:    mask = 4'b0111;
            default: mask = 4'b1111;
        endcase
        block    = (state == RESP) ? (4'b0001 << w_q) : 4'b0000;
        eligible = req & mask & ~block;
        // A shrinking noc can leave the pointer outside the active range.
        start    = ({1'b0, ptr} >= noc_eff) ? 2'd0 : ptr;
        found    = 1'b0;
        win      = 2'd0;
        idx      = 3'd0;
        for (int i = 0; i < NCORES; i++) begin
            idx = {1'b0, start} + 3'(i);
            if (idx >= noc_eff) idx = idx - noc_eff;
            if (!found && (3'(i) < noc_eff) && eligible[idx[SEL_W-1:0]]) begin
                found = 1'b1;
                win   = idx[SEL_W-1:0];
            end
        end
        win_inc = {1'b0, win} + 3'd1;
        ptr_win = (win_inc >= noc_eff) ? 2'd0 : win_inc[SEL_W-1:0];
    end

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        w_nxt           = w_q;
        we_nxt          = we_q;
        grant_nxt       = '0;
        mem_sel_nxt     = '0;
        mem_we_nxt      = 1'b0;
        data_out_en_nxt = '0;
        done_nxt        = '0;
        busy_nxt        = 1'b0;
        case (state)
            IDLE, RESP: begin
                state_nxt = IDLE;
                if (found) begin
                    state_nxt   = GRANT;
                    w_nxt       = win;
                    we_nxt      = we[win];
                    ptr_nxt     = ptr_win;
                    grant_nxt   = 4'b0001 << win;
                    mem_sel_nxt = win;
                    mem_we_nxt  = we[win];
                    busy_nxt    = 1'b1;
                end
            end
            GRANT: begin
                state_nxt       = RESP;
                mem_sel_nxt     = w_q;
                done_nxt        = 4'b0001 << w_q;
                data_out_en_nxt = we_q ? 4'b0000 : (4'b0001 << w_q);
                busy_nxt        = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            w_q         <= '0;
            we_q        <= 1'b0;
            grant       <= '0;
            mem_sel     <= '0;
            mem_we      <= 1'b0;
            data_out_en <= '0;
            done        <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            w_q         <= w_nxt;
            we_q        <= we_nxt;
            grant       <= grant_nxt;
            mem_sel     <= mem_sel_nxt;
            mem_we      <= mem_we_nxt;
            data_out_en <= data_out_en_nxt;
            done        <= done_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] noc;
    logic [3:0] req, we;
    logic [3:0] grant, data_out_en, done;
    logic [1:0] mem_sel;
    logic       mem_we, busy;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int         m_mode = 0;   // 0 idle, 1 port granted, 2 responding
    int         m_ptr  = 0;
    int         m_w    = 0;
    bit         m_we   = 0;
    logic [3:0] e_grant, e_done, e_doe;
    logic [1:0] e_sel;
    logic       e_mwe, e_busy;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst), .noc(noc), .req(req), .we(we),
        .grant(grant), .mem_sel(mem_sel), .mem_we(mem_we),
        .data_out_en(data_out_en), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int n, input int p, input int excl);
        int s;
        s = (p >= n) ? 0 : p;
        for (int k = 0; k < n; k++) begin
            int c;
            c = (s + k) % n;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_update(input logic r, input logic [2:0] nn, input logic [3:0] q, input logic [3:0] w);
        int n, c;
        n = (nn == 0) ? 1 : ((nn > 4) ? 4 : int'(nn));
        e_grant = 0; e_done = 0; e_doe = 0; e_sel = 0; e_mwe = 0; e_busy = 0;
        if (r) begin
            m_mode = 0;
            m_ptr  = 0;
        end else if (m_mode == 1) begin
            e_done = 4'(1 << m_w);
            e_doe  = m_we ? 4'b0 : 4'(1 << m_w);
            e_busy = 1;
            m_mode = 2;
        end else begin
            c = pick(q, n, m_ptr, (m_mode == 2) ? m_w : -1);
            if (c >= 0) begin
                m_w     = c;
                m_we    = w[c];
                m_ptr   = (c + 1) % n;
                e_grant = 4'(1 << c);
                e_sel   = c[1:0];
                e_mwe   = m_we;
                e_busy  = 1;
                m_mode  = 1;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [2:0] n, input logic [3:0] q, input logic [3:0] w);
        rst = r; noc = n; req = q; we = w;
        model_update(r, n, q, w);
        @(posedge clk);
        #1;
        check_eq("grant", {4'b0, grant}, {4'b0, e_grant});
        check_eq("done", {4'b0, done}, {4'b0, e_done});
        check_eq("data_out_en", {4'b0, data_out_en}, {4'b0, e_doe});
        check_eq("mem_we", {7'b0, mem_we}, {7'b0, e_mwe});
        check_eq("busy", {7'b0, busy}, {7'b0, e_busy});
        if (e_grant != 0 || !e_busy)
            check_eq("mem_sel", {6'b0, mem_sel}, {6'b0, e_sel});
    endtask

    logic [3:0] rr_exp [5];
    logic [3:0] q, w, dm, dh;
    logic [2:0] n;
    logic       r;

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset with all requests pending
        step(1, 3'd4, 4'b1111, 4'b0000);
        step(1, 3'd4, 4'b1111, 4'b0000);
        check_eq("rst_busy", {7'b0, busy}, 8'd0);
        check_eq("rst_grant", {4'b0, grant}, 8'd0);
        step(0, 3'd4, 4'b1111, 4'b0000);
        check_eq("rst_first_grant", {4'b0, grant}, 8'h01);

        // single read with one active core
        step(1, 3'd1, 4'b0000, 4'b0000);
        step(0, 3'd1, 4'b0001, 4'b0000);
        check_eq("sr_grant", {4'b0, grant}, 8'h01);
        step(0, 3'd1, 4'b0001, 4'b0000);
        check_eq("sr_done", {4'b0, done}, 8'h01);
        check_eq("sr_doe", {4'b0, data_out_en}, 8'h01);
        step(0, 3'd1, 4'b0000, 4'b0000);
        check_eq("sr_idle_busy", {7'b0, busy}, 8'd0);

        // round-robin writes
        step(1, 3'd4, 4'b0000, 4'b0000);
        for (int i = 1; i <= 10; i++) begin
            step(0, 3'd4, 4'b1111, 4'b1111);
            if (i % 2 == 1) begin
                check_eq("rr_grant", {4'b0, grant}, {4'b0, rr_exp[(i - 1) / 2]});
                check_eq("rr_mem_we", {7'b0, mem_we}, 8'd1);
            end
        end

        // core-count mask
        step(1, 3'd2, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(0, 3'd2, 4'b1111, 4'b0000);
            check_eq("mask_hi", {4'b0, grant & 4'b1100}, 8'd0);
        end

        // fairness: pointer at 3 after core 2
        step(1, 3'd4, 4'b0000, 4'b0000);
        step(0, 3'd4, 4'b0100, 4'b0000);
        step(0, 3'd4, 4'b0100, 4'b0000);
        step(0, 3'd4, 4'b1010, 4'b0000);
        check_eq("fair_core3", {4'b0, grant}, 8'h08);
        step(0, 3'd4, 4'b1010, 4'b0000);
        step(0, 3'd4, 4'b1010, 4'b0000);
        check_eq("fair_core1", {4'b0, grant}, 8'h02);

        // reset during a GRANT cycle
        step(1, 3'd4, 4'b0000, 4'b0000);
        step(0, 3'd4, 4'b0010, 4'b0000);
        check_eq("rm_grant1", {4'b0, grant}, 8'h02);
        step(1, 3'd4, 4'b0010, 4'b0000);
        check_eq("rm_done", {4'b0, done}, 8'd0);
        check_eq("rm_doe", {4'b0, data_out_en}, 8'd0);
        step(0, 3'd4, 4'b0011, 4'b0000);
        check_eq("rm_first", {4'b0, grant}, 8'h01);

        // randomized traffic
        step(1, 3'd4, 4'b0000, 4'b0000);
        q = 0; w = 0; n = 3'd4; dh = 0;
        for (int t = 0; t < 400; t++) begin
            dm = dh;
            dh = e_done;
            for (int i = 0; i < 4; i++) begin
                if (q[i]) begin
                    if (dm[i] && $urandom_range(0, 3) != 0) q[i] = 1'b0;
                end else if ($urandom_range(0, 9) < 3) begin
                    q[i] = 1'b1;
                    w[i] = 1'($urandom_range(0, 1));
                end
            end
            if ($urandom_range(0, 19) == 0) n = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 49) == 0);
            step(r, n, q, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
